pq_tree_kv: RTL and testbench
=============================

Name: pq_tree_kv

Overview:
- Pipelined binary-tree (systolic) priority queue holding key/payload pairs.
- Next generation of the team's tree priority queue, with these additions:
  - parametrised key and payload widths;
  - selectable max-first or min-first ordering;
  - simultaneous enqueue+dequeue (replace);
  - occupancy, full and empty status.
- Sits between schedulers and execution units as a sorted ready-queue.
- One operation travels down one tree level per cycle.

Parameters:
- L, 3: tree levels. Capacity CAP = 2^L - 1 entries.
- KW, 32: key width.
- DW, 8: payload width. Travels with its key and is never compared.
- MIN_FIRST, 0: ordering. 0 = larger key has priority; 1 = smaller key has priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- enq_valid  in  1  enqueue request
- enq_key  in  KW  key to insert
- enq_data  in  DW  payload to insert
- enq_ready  out  1  enqueue can be accepted this cycle
- deq_req  in  1  dequeue request
- deq_ready  out  1  dequeue can be accepted this cycle
- deq_valid  out  1  dequeue result valid (one-cycle pulse)
- deq_key  out  KW  dequeued key
- deq_data  out  DW  dequeued payload
- count  out  L  number of stored entries
- empty  out  1  count == 0
- full  out  1  count == CAP

Interface: one clock; reset is synchronous and active-low.
- Clock port is clk; reset port is rst_n.
- rst_n is sampled on the clk rising edge.

Behaviour:
- Reset (rst_n low at a clk edge):
  - all nodes are cleared to inactive, all level tokens to NOP;
  - count = 0, empty = 1, full = 0, deq_valid = 0, deq_key = 0, deq_data = 0.
  - Tokens in flight are dropped; no partial writes survive.
- Node contents: active bit, key, payload, and a subtree occupancy counter sized to that level's subtree.
- Per-level token states: NOP, ENQ, DEQ, REP. Each non-NOP token carries a position and a key/payload.
- idle = root token is NOP.
  - enq_ready = idle && !full.
  - deq_ready = idle && !empty.
  - An accepted operation makes the root non-idle for exactly one cycle, so the maximum issue rate is one operation every 2 cycles.
- Acceptance:
  - Enqueue fires when enq_valid && enq_ready.
  - Dequeue fires when deq_req && deq_ready.
  - Both firing together is REP (replace).
  - When enq_valid && deq_req arrive while empty, only the enqueue fires.
- Timing: an operation accepted at edge t is handled at level l during cycle t+1+l and reaches the leaves after L cycles.
- Output (dequeue or replace):
  - deq_valid = 1 for exactly the cycle after acceptance.
  - deq_key/deq_data = root contents before the update.
  - Outside that cycle deq_valid = 0 and deq_key/deq_data hold their last value.
- "Better" means larger key (MIN_FIRST=0) or smaller key (MIN_FIRST=1).
- ENQ at a node:
  - An inactive node stores the token.
  - Otherwise the node keeps the better of {stored, token}; on equal keys the stored entry wins.
  - The loser moves down to the child with the smaller subtree occupancy (left on equal occupancy).
  - Occupancy increments along the path.
- DEQ at a node:
  - The node takes the better active child; left wins ties.
  - The token follows that child.
  - With no active child, the node goes inactive and the token ends.
  - Occupancy decrements along the path.
- REP at a node:
  - If the better active child is strictly better than the token, the node takes the child and the token (new entry) descends to that child.
  - Otherwise the node stores the token and the token ends.
  - Occupancy is unchanged.
- count: +1 the cycle after an ENQ is accepted, -1 after a DEQ, unchanged after a REP. Never wraps.
- The 2-cycle issue spacing guarantees the level l+1 state read by level l is already final; no further hazard logic exists.

Optional Feature:
- Macro: PQ_TREE_KV_PEEK_EN.
- When defined, three extra outputs are added:
  - peek_valid (1): root active bit;
  - peek_key (KW): root key;
  - peek_data (DW): root payload.
- All three are taken directly from the root registers with no added latency and read 0 after reset.
- When undefined, the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n low 3 cycles, with enq_valid=1 during reset -> enq_ready=1, deq_ready=0, empty=1, count=0, deq_valid=0 after release; nothing is stored.
- Ordering (L=3, MIN_FIRST=0): enqueue keys 0x4, 0x44, 0x444, then dequeue 3 times -> deq_key 0x444, 0x44, 0x4; count goes 3->0; empty=1.
- Full: enqueue keys 1..7 -> full=1, enq_ready=0; an 8th enq_valid with key 9 is ignored and count stays 7; dequeues return 7,6,5,4,3,2,1.
- Replace: queue {10,20,30}; enq key 25 with deq_req in the same cycle -> deq_key 30, count stays 3; later dequeues return 25, 20, 10.
- Tie and payload: enq (5,0xA), then (5,0xB), then (3,0xC) -> dequeues return data 0xA, 0xB, 0xC.
- MIN_FIRST=1 and reset mid-flight:
  - enq 7, 2, 9 -> first dequeue returns 2;
  - asserting rst_n low one cycle after accepting an enqueue -> count=0, empty=1, no later deq_valid.

Source files
------------

// File: rtl/pq_tree_kv_if.sv
// pq_tree_kv_if: enqueue/dequeue/status bundle for pq_tree_kv.
// The peek_* signals exist only when PQ_TREE_KV_PEEK_EN is defined.
interface pq_tree_kv_if #(
  parameter int L  = 3,
  parameter int KW = 32,
  parameter int DW = 8
);
  logic          enq_valid, enq_ready, deq_req, deq_ready, deq_valid, empty, full;
  logic [KW-1:0] enq_key, deq_key;
  logic [DW-1:0] enq_data, deq_data;
  logic [L-1:0]  count;
`ifdef PQ_TREE_KV_PEEK_EN
  logic          peek_valid;
  logic [KW-1:0] peek_key;
  logic [DW-1:0] peek_data;
`endif
  modport slave (
    input  enq_valid, enq_key, enq_data, deq_req,
    output enq_ready, deq_ready, deq_valid, deq_key, deq_data, count, empty, full
`ifdef PQ_TREE_KV_PEEK_EN
    , output peek_valid, peek_key, peek_data
`endif
  );
  modport master (
    output enq_valid, enq_key, enq_data, deq_req,
    input  enq_ready, deq_ready, deq_valid, deq_key, deq_data, count, empty, full
`ifdef PQ_TREE_KV_PEEK_EN
    , input peek_valid, peek_key, peek_data
`endif
  );
endinterface

// File: rtl/pq_tree_kv.sv
// pq_tree_kv: pipelined binary-tree priority queue of key/payload pairs, one tree level per cycle.
// Define PQ_TREE_KV_PEEK_EN to expose the root entry on peek_valid/peek_key/peek_data.
module pq_tree_kv #(
  parameter int L         = 3,
  parameter int KW        = 32,
  parameter int DW        = 8,
  parameter bit MIN_FIRST = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  pq_tree_kv_if.slave pq
);
  localparam int CAP = 2**L - 1;
  typedef enum logic [1:0] {NOP, ENQ, DEQ, REP} op_e;
  logic [CAP-1:0] act_q, act_d;
  logic [KW-1:0]  key_q [CAP];
  logic [KW-1:0]  key_d [CAP];
  logic [DW-1:0]  dat_q [CAP];
  logic [DW-1:0]  dat_d [CAP];
  logic [L-1:0]   occ_q [CAP];
  logic [L-1:0]   occ_d [CAP];
  op_e            op_q [L];
  op_e            op_d [L];
  logic [L-1:0]   pos_q [L];
  logic [L-1:0]   pos_d [L];
  logic [KW-1:0]  tk_q [L];
  logic [KW-1:0]  tk_d [L];
  logic [DW-1:0]  td_q [L];
  logic [DW-1:0]  td_d [L];
  logic [L-1:0]   cnt_q, cnt_d;
  logic           dv_q;
  logic [KW-1:0]  dk_q;
  logic [DW-1:0]  dd_q;
  logic           idle, enq_fire, deq_fire;
  function automatic logic better(input logic [KW-1:0] a, input logic [KW-1:0] b);
    return MIN_FIRST ? (a < b) : (a > b);
  endfunction
  assign idle         = op_q[0] == NOP;
  assign pq.enq_ready = idle && !pq.full;
  assign pq.deq_ready = idle && !pq.empty;
  assign enq_fire     = pq.enq_valid && pq.enq_ready;
  assign deq_fire     = pq.deq_req && pq.deq_ready;
  assign cnt_d        = cnt_q + L'(enq_fire && !deq_fire) - L'(deq_fire && !enq_fire);
  assign pq.count     = cnt_q;
  assign pq.empty     = cnt_q == '0;
  assign pq.full      = cnt_q == L'(CAP);
  assign pq.deq_valid = dv_q;
  assign pq.deq_key   = dk_q;
  assign pq.deq_data  = dd_q;
`ifdef PQ_TREE_KV_PEEK_EN
  assign pq.peek_valid = act_q[0];
  assign pq.peek_key   = key_q[0];
  assign pq.peek_data  = dat_q[0];
`endif
  // Levels are evaluated leaf-first so each level sees its children's post-update (_d) state.
  always_comb begin
    int p, lc, rc, c, n;
    logic kids, la, ra, hk, sw;
    act_d = act_q;
    key_d = key_q;
    dat_d = dat_q;
    occ_d = occ_q;
    op_d[0]  = enq_fire ? (deq_fire ? REP : ENQ) : (deq_fire ? DEQ : NOP);
    pos_d[0] = '0;
    tk_d[0]  = pq.enq_key;
    td_d[0]  = pq.enq_data;
    for (int l = 1; l < L; l++) begin
      op_d[l]  = NOP;
      pos_d[l] = '0;
      tk_d[l]  = '0;
      td_d[l]  = '0;
    end
    p = 0; lc = 0; rc = 0; c = 0; n = 0;
    kids = 1'b0; la = 1'b0; ra = 1'b0; hk = 1'b0; sw = 1'b0;
    for (int l = L - 1; l >= 0; l--) begin
      p    = int'(pos_q[l]);
      kids = l < L - 1;
      n    = kids ? l + 1 : l;
      lc   = kids ? 2 * p + 1 : 0;
      rc   = kids ? 2 * p + 2 : 0;
      la   = kids && act_d[lc];
      ra   = kids && act_d[rc];
      c    = (ra && (!la || better(key_d[rc], key_d[lc]))) ? rc : lc;
      hk   = la || ra;
      sw   = better(tk_q[l], key_q[p]);
      case (op_q[l])
        ENQ: begin
          occ_d[p] = occ_q[p] + 1'b1;
          act_d[p] = 1'b1;
          if (!act_q[p] || sw) begin
            key_d[p] = tk_q[l];
            dat_d[p] = td_q[l];
          end
          if (act_q[p] && kids) begin
            op_d[n]  = ENQ;
            pos_d[n] = L'(occ_d[rc] < occ_d[lc] ? rc : lc);
            tk_d[n]  = sw ? key_q[p] : tk_q[l];
            td_d[n]  = sw ? dat_q[p] : td_q[l];
          end
        end
        DEQ: begin
          occ_d[p] = occ_q[p] - 1'b1;
          act_d[p] = hk;
          if (hk) begin
            key_d[p] = key_d[c];
            dat_d[p] = dat_d[c];
            op_d[n]  = DEQ;
            pos_d[n] = L'(c);
          end
        end
        REP: begin
          if (hk && better(key_d[c], tk_q[l])) begin
            key_d[p] = key_d[c];
            dat_d[p] = dat_d[c];
            op_d[n]  = REP;
            pos_d[n] = L'(c);
            tk_d[n]  = tk_q[l];
            td_d[n]  = td_q[l];
          end else begin
            key_d[p] = tk_q[l];
            dat_d[p] = td_q[l];
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q <= '0;
      key_q <= '{default: '0};
      dat_q <= '{default: '0};
      occ_q <= '{default: '0};
      op_q  <= '{default: NOP};
      pos_q <= '{default: '0};
      tk_q  <= '{default: '0};
      td_q  <= '{default: '0};
      cnt_q <= '0;
      dv_q  <= 1'b0;
      dk_q  <= '0;
      dd_q  <= '0;
    end else begin
      act_q <= act_d;
      key_q <= key_d;
      dat_q <= dat_d;
      occ_q <= occ_d;
      op_q  <= op_d;
      pos_q <= pos_d;
      tk_q  <= tk_d;
      td_q  <= td_d;
      cnt_q <= cnt_d;
      dv_q  <= deq_fire;
      if (deq_fire) begin
        dk_q <= key_q[0];
        dd_q <= dat_q[0];
      end
    end
  end
endmodule

// File: tb/tb_pq_tree_kv.sv
// tb_pq_tree_kv: vector table plus dequeue scoreboard for pq_tree_kv, max-first and min-first instances.
module tb_pq_tree_kv;
  typedef struct {
    logic        ev;
    logic [31:0] k;
    logic [7:0]  d;
    logic        dq;
    logic [31:0] xk;
    logic [7:0]  xd;
    int          xc;
  } vec_t;
  typedef struct {
    logic [31:0] k;
    logic [7:0]  d;
  } exp_t;
  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  vec_t vt[$];
  always #5 clk = ~clk;
  pq_tree_kv_if #(.L(3), .KW(32), .DW(8)) b0 ();
  pq_tree_kv_if #(.L(3), .KW(32), .DW(8)) b1 ();
  pq_tree_kv #(.L(3), .KW(32), .DW(8), .MIN_FIRST(1'b0)) u0 (.clk(clk), .rst_n(rst0_n), .pq(b0));
  pq_tree_kv #(.L(3), .KW(32), .DW(8), .MIN_FIRST(1'b1)) u1 (.clk(clk), .rst_n(rst1_n), .pq(b1));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic ev, input int k, input int d, input logic dq,
                              input int xk, input int xd, input int xc);
    vec_t v;
    v = '{ev, 32'(k), 8'(d), dq, 32'(xk), 8'(xd), xc};
    return v;
  endfunction
  always @(negedge clk) begin
    if (b0.deq_valid) begin
      if (sb0.size() == 0) chk("deq0_spurious", 32'(b0.deq_valid), 32'd0);
      else begin
        e0 = sb0.pop_front();
        chk("deq0_key", b0.deq_key, e0.k);
        chk("deq0_data", 32'(b0.deq_data), 32'(e0.d));
      end
    end
  end
  always @(negedge clk) begin
    if (b1.deq_valid) begin
      if (sb1.size() == 0) chk("deq1_spurious", 32'(b1.deq_valid), 32'd0);
      else begin
        e1 = sb1.pop_front();
        chk("deq1_key", b1.deq_key, e1.k);
        chk("deq1_data", 32'(b1.deq_data), 32'(e1.d));
      end
    end
  end
  task automatic apply(input vec_t v);
    b0.enq_valid = v.ev;
    b0.enq_key   = v.k;
    b0.enq_data  = v.d;
    b0.deq_req   = v.dq;
    if (v.dq) sb0.push_back('{v.xk, v.xd});
    @(posedge clk); #1;
    b0.enq_valid = 1'b0;
    b0.deq_req   = 1'b0;
    @(posedge clk); #1;
    chk("count", 32'(b0.count), 32'(v.xc));
    chk("empty", 32'(b0.empty), 32'(v.xc == 0));
    chk("full", 32'(b0.full), 32'(v.xc == 7));
    chk("enq_ready", 32'(b0.enq_ready), 32'(v.xc < 7));
    chk("deq_ready", 32'(b0.deq_ready), 32'(v.xc > 0));
  endtask
  task automatic op1(input logic e, input int k, input logic dq, input int xk, input int xc);
    b1.enq_valid = e;
    b1.enq_key   = 32'(k);
    b1.enq_data  = 8'(k);
    b1.deq_req   = dq;
    if (dq) sb1.push_back('{32'(xk), 8'(xk)});
    @(posedge clk); #1;
    b1.enq_valid = 1'b0;
    b1.deq_req   = 1'b0;
    @(posedge clk); #1;
    chk("count1", 32'(b1.count), 32'(xc));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    b0.enq_valid = 1'b1; b0.enq_key = 32'h99; b0.enq_data = 8'h99; b0.deq_req = 1'b0;
    b1.enq_valid = 1'b0; b1.enq_key = '0; b1.enq_data = '0; b1.deq_req = 1'b0;
    vt.push_back(mk(1, 'h4, 1, 0, 0, 0, 1));
    vt.push_back(mk(1, 'h44, 2, 0, 0, 0, 2));
    vt.push_back(mk(1, 'h444, 3, 0, 0, 0, 3));
    vt.push_back(mk(0, 0, 0, 1, 'h444, 3, 2));
    vt.push_back(mk(0, 0, 0, 1, 'h44, 2, 1));
    vt.push_back(mk(0, 0, 0, 1, 'h4, 1, 0));
    for (int i = 1; i <= 7; i++) vt.push_back(mk(1, i, i, 0, 0, 0, i));
    vt.push_back(mk(1, 9, 9, 0, 0, 0, 7));
    for (int i = 7; i >= 1; i--) vt.push_back(mk(0, 0, 0, 1, i, i, i - 1));
    vt.push_back(mk(1, 10, 1, 0, 0, 0, 1));
    vt.push_back(mk(1, 20, 2, 0, 0, 0, 2));
    vt.push_back(mk(1, 30, 3, 0, 0, 0, 3));
    vt.push_back(mk(1, 25, 4, 1, 30, 3, 3));
    vt.push_back(mk(0, 0, 0, 1, 25, 4, 2));
    vt.push_back(mk(0, 0, 0, 1, 20, 2, 1));
    vt.push_back(mk(0, 0, 0, 1, 10, 1, 0));
    vt.push_back(mk(1, 5, 'hA, 0, 0, 0, 1));
    vt.push_back(mk(1, 5, 'hB, 0, 0, 0, 2));
    vt.push_back(mk(1, 3, 'hC, 0, 0, 0, 3));
    vt.push_back(mk(0, 0, 0, 1, 5, 'hA, 2));
    vt.push_back(mk(0, 0, 0, 1, 5, 'hB, 1));
    vt.push_back(mk(0, 0, 0, 1, 3, 'hC, 0));
    repeat (3) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    b0.enq_valid = 1'b0;
    chk("rst_enq_ready", 32'(b0.enq_ready), 32'd1);
    chk("rst_deq_ready", 32'(b0.deq_ready), 32'd0);
    chk("rst_empty", 32'(b0.empty), 32'd1);
    chk("rst_full", 32'(b0.full), 32'd0);
    chk("rst_count", 32'(b0.count), 32'd0);
    chk("rst_deq_valid", 32'(b0.deq_valid), 32'd0);
    chk("rst_deq_key", b0.deq_key, 32'd0);
    @(posedge clk); #1;
    chk("rst_nothing_stored", 32'(b0.count), 32'd0);
    b0.enq_valid = 1'b1; b0.enq_key = 32'h50; b0.enq_data = 8'h5; b0.deq_req = 1'b1;
    @(posedge clk); #1;
    b0.enq_valid = 1'b0; b0.deq_req = 1'b0;
    chk("busy_enq_ready", 32'(b0.enq_ready), 32'd0);
    chk("busy_deq_ready", 32'(b0.deq_ready), 32'd0);
    chk("both_on_empty_count", 32'(b0.count), 32'd1);
    @(posedge clk); #1;
    chk("idle_enq_ready", 32'(b0.enq_ready), 32'd1);
    chk("idle_deq_ready", 32'(b0.deq_ready), 32'd1);
    apply(mk(0, 0, 0, 1, 'h50, 5, 0));
    foreach (vt[i]) apply(vt[i]);
    chk("deq_key_hold", b0.deq_key, 32'd3);
    op1(1, 7, 0, 0, 1);
    op1(1, 2, 0, 0, 2);
    op1(1, 9, 0, 0, 3);
    op1(0, 0, 1, 2, 2);
    b1.enq_valid = 1'b1; b1.enq_key = 32'd1; b1.enq_data = 8'd1;
    @(posedge clk); #1;
    b1.enq_valid = 1'b0;
    chk("mid_count_before_rst", 32'(b1.count), 32'd3);
    rst1_n = 1'b0;
    @(posedge clk); #1;
    rst1_n = 1'b1;
    chk("mid_rst_count", 32'(b1.count), 32'd0);
    chk("mid_rst_empty", 32'(b1.empty), 32'd1);
    chk("mid_rst_deq_ready", 32'(b1.deq_ready), 32'd0);
    b1.deq_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    b1.deq_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_count_late", 32'(b1.count), 32'd0);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
